// File: rtl/enigma_pkg.sv
// ============================================================================
// enigma_pkg : shared letter-code constants, rotor II wiring and mod-26 add
// Revision   : 1.0
// ============================================================================
`default_nettype none

package enigma_pkg;

  localparam int                    LETTER_W    = 6;
  localparam int                    NUM_LETTERS = 26;
  localparam logic [LETTER_W-1:0]   BAD_CODE    = 6'd63;

  localparam logic [LETTER_W-1:0] ROTOR2_WIRING [NUM_LETTERS] = '{
    6'd6,  6'd11, 6'd16, 6'd24, 6'd22, 6'd1,  6'd19, 6'd8,  6'd25,
    6'd3,  6'd15, 6'd18, 6'd5,  6'd10, 6'd0,  6'd13, 6'd9,  6'd2,
    6'd20, 6'd23, 6'd17, 6'd4,  6'd21, 6'd12, 6'd14, 6'd7
  };

  // Operands are assumed 0..25, so one conditional subtract is enough.
  function automatic logic [LETTER_W-1:0] mod26_add(
    input logic [LETTER_W-1:0] a,
    input logic [LETTER_W-1:0] b
  );
    logic [LETTER_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= (LETTER_W+1)'(NUM_LETTERS))
      sum = sum - (LETTER_W+1)'(NUM_LETTERS);
    return sum[LETTER_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rotor2_wiring_rom.sv
// ============================================================================
// rotor2_wiring_rom : combinational rotor II forward wiring lookup
// Revision          : 1.0
// ============================================================================
`default_nettype none

module rotor2_wiring_rom
  import enigma_pkg::*;
(
  input  logic [LETTER_W-1:0] idx,
  output logic [LETTER_W-1:0] letter
);

  always_comb begin
    letter = BAD_CODE;
    if (idx < LETTER_W'(NUM_LETTERS))
      letter = ROTOR2_WIRING[idx[4:0]];
  end

endmodule

`default_nettype wire

// File: rtl/forward_rotor2_step.sv
// ============================================================================
// forward_rotor2_step : stepping rotor II, forward path, valid/ready in and out
// Revision            : 1.0
// ============================================================================
`default_nettype none

module forward_rotor2_step
  import enigma_pkg::*;
#(
  parameter logic [LETTER_W-1:0] NOTCH = 6'd4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [LETTER_W-1:0] load_pos,
  input  logic                step_in,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LETTER_W-1:0] data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LETTER_W-1:0] data_out,
  output logic                err,
  output logic [LETTER_W-1:0] pos_out,
  output logic                carry_out
);

  logic [LETTER_W-1:0] pos_q, pos_d;
  logic                out_valid_q, out_valid_d;
  logic [LETTER_W-1:0] data_out_q, data_out_d;
  logic                err_q, err_d;
  logic                carry_q, carry_d;

  logic                accept;
  logic                do_step;
  logic                bad_in;
  logic [LETTER_W-1:0] pos_next;
  logic [LETTER_W-1:0] pos_eff;
  logic [LETTER_W-1:0] rom_idx;
  logic [LETTER_W-1:0] rom_letter;

  assign in_ready = (!out_valid_q || out_ready) && !load;
  assign accept   = in_valid && in_ready;
  assign do_step  = accept && step_in;
  assign bad_in   = (data_in >= LETTER_W'(NUM_LETTERS));
  assign pos_next = mod26_add(pos_q, 6'd1);
  // The rotor steps before the character passes through it.
  assign pos_eff  = do_step ? pos_next : pos_q;
  assign rom_idx  = bad_in ? BAD_CODE : mod26_add(data_in, pos_eff);

  rotor2_wiring_rom u_rom (
    .idx    (rom_idx),
    .letter (rom_letter)
  );

  always_comb begin
    pos_d       = pos_q;
    out_valid_d = out_valid_q;
    data_out_d  = data_out_q;
    err_d       = err_q;
    carry_d     = do_step && (pos_q == NOTCH);

    // load blocks in_ready, so it never coincides with a step.
    if (load && (load_pos < LETTER_W'(NUM_LETTERS)))
      pos_d = load_pos;
    else if (do_step)
      pos_d = pos_next;

    if (accept) begin
      out_valid_d = 1'b1;
      data_out_d  = bad_in ? BAD_CODE : rom_letter;
      err_d       = bad_in;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q       <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      err_q       <= 1'b0;
      carry_q     <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      out_valid_q <= out_valid_d;
      data_out_q  <= data_out_d;
      err_q       <= err_d;
      carry_q     <= carry_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign err       = err_q;
  assign pos_out   = pos_q;
  assign carry_out = carry_q;

endmodule

`default_nettype wire

// File: tb/tb_forward_rotor2_step.sv
// ============================================================================
// tb_forward_rotor2_step : directed self-checking bench for forward_rotor2_step
// Revision               : 1.0
// ============================================================================
`default_nettype none

module tb_forward_rotor2_step;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [5:0] load_pos;
  logic       step_in;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] data_in;
  logic       out_valid;
  logic       out_ready;
  logic [5:0] data_out;
  logic       err;
  logic [5:0] pos_out;
  logic       carry_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  forward_rotor2_step #(.NOTCH(6'd4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_pos  (load_pos),
    .step_in   (step_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .err       (err),
    .pos_out   (pos_out),
    .carry_out (carry_out)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] din, input logic stp);
    in_valid = 1'b1;
    data_in  = din;
    step_in  = stp;
    tick();
    in_valid = 1'b0;
    step_in  = 1'b0;
  endtask

  task automatic load_position(input logic [5:0] p);
    load     = 1'b1;
    load_pos = p;
    tick();
    load     = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; load_pos = '0; step_in = 1'b0;
    in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
    #12;
    check_eq("rst_pos",       pos_out,   0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_data_out",  data_out,  0);
    check_eq("rst_err",       err,       0);
    check_eq("rst_carry",     carry_out, 0);
    check_eq("rst_in_ready",  in_ready,  1);
    rst_n = 1'b1;

    // Position 0, no step: A -> G
    send(6'd0, 1'b0);
    check_eq("a_nostep_data", data_out,  6);
    check_eq("a_nostep_pos",  pos_out,   0);
    check_eq("a_nostep_vld",  out_valid, 1);

    // Step to 1 first, then encipher: A -> L
    send(6'd0, 1'b1);
    check_eq("a_step_data", data_out, 11);
    check_eq("a_step_pos",  pos_out,  1);

    // Load holds off input and leaves the pending result alone
    out_ready = 1'b0;
    load = 1'b1; load_pos = 6'd4; in_valid = 1'b1; data_in = 6'd9;
    #1;
    check_eq("load_in_ready", in_ready, 0);
    tick();
    load = 1'b0; in_valid = 1'b0;
    check_eq("load4_pos",      pos_out,   4);
    check_eq("load_keep_vld",  out_valid, 1);
    check_eq("load_keep_data", data_out,  11);

    // Turnover E -> F: A at pos 5 -> B, carry pulses once
    out_ready = 1'b1;
    send(6'd0, 1'b1);
    check_eq("notch_pos",   pos_out,   5);
    check_eq("notch_data",  data_out,  1);
    check_eq("notch_carry", carry_out, 1);
    tick();
    check_eq("carry_pulse_end", carry_out, 0);
    check_eq("vld_cleared",     out_valid, 0);

    // 25 wraps to 0 with no carry
    load_position(6'd25);
    check_eq("load25_pos", pos_out, 25);
    send(6'd0, 1'b1);
    check_eq("wrap_pos",   pos_out,   0);
    check_eq("wrap_data",  data_out,  6);
    check_eq("wrap_carry", carry_out, 0);

    // Backpressure: result held, step ignored while stalled
    out_ready = 1'b0;
    in_valid = 1'b1; data_in = 6'd7; step_in = 1'b1;
    #1;
    check_eq("bp_in_ready", in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("bp_vld",      out_valid, 1);
      check_eq("bp_data",     data_out,  6);
      check_eq("bp_pos",      pos_out,   0);
      check_eq("bp_in_ready", in_ready,  0);
    end
    out_ready = 1'b1;
    #1;
    check_eq("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0; step_in = 1'b0;
    check_eq("bp_accept_pos",  pos_out,   1);
    check_eq("bp_accept_data", data_out,  25);
    check_eq("bp_accept_vld",  out_valid, 1);

    // Out-of-range letter still steps
    send(6'd30, 1'b1);
    check_eq("bad_pos",  pos_out,  2);
    check_eq("bad_data", data_out, 63);
    check_eq("bad_err",  err,      1);
    load_position(6'd40);
    check_eq("load40_ignored", pos_out,  2);
    check_eq("load40_data",    data_out, 63);
    send(6'd25, 1'b0);
    check_eq("z_pos2_data", data_out, 11);
    check_eq("z_pos2_err",  err,      0);

    // Index wrap: D at pos 25 -> (3+25) mod 26 = 2 -> Q
    load_position(6'd24);
    send(6'd3, 1'b1);
    check_eq("idxwrap_pos",  pos_out,  25);
    check_eq("idxwrap_data", data_out, 16);

    // Asynchronous reset while a result and carry are pending
    load_position(6'd4);
    out_ready = 1'b0;
    send(6'd2, 1'b1);
    check_eq("pre_rst_data",  data_out,  8);
    check_eq("pre_rst_carry", carry_out, 1);
    check_eq("pre_rst_vld",   out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_vld",   out_valid, 0);
    check_eq("async_rst_pos",   pos_out,   0);
    check_eq("async_rst_carry", carry_out, 0);
    check_eq("async_rst_data",  data_out,  0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", in_ready, 1);
    tick();
    check_eq("post_rst_vld", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/forward_rotor2_step.md
FORWARD_ROTOR2_STEP -- requirements
Module: forward_rotor2_step

Interface
REQ-001 Parameter NOTCH, default 6'd4 (E), is the position whose step-away asserts carry (turnover E->F).
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 load  input  1  load ring position from load_pos this cycle.
REQ-005 load_pos  input  6  new position, 0..25.
REQ-006 step_in  input  1  qualifier: advance position with the accepted character.
REQ-007 in_valid  input  1  data_in holds a character.
REQ-008 in_ready  output  1  block can accept a character this cycle.
REQ-009 data_in  input  6  plaintext letter code, A=0..Z=25.
REQ-010 out_valid  output  1  data_out/err hold a result.
REQ-011 out_ready  input  1  downstream consumes the result this cycle.
REQ-012 data_out  output  6  forward-enciphered letter code.
REQ-013 err  output  1  result came from an out-of-range data_in.
REQ-014 pos_out  output  6  current rotor position.
REQ-015 carry_out  output  1  one-cycle pulse: rotor stepped away from NOTCH.

Function
REQ-016 Wiring W (index A..Z) SHALL be G L Q Y W B T I Z D P S F K A N J C U X R E V M O H, i.e. 6,11,16,24,22,1,19,8,25,3,15,18,5,10,0,13,9,2,20,23,17,4,21,12,14,7.
REQ-017 Result SHALL be data_out = W[(data_in + P) mod 26], P = position in effect; exact inverse of the reverse-path rotor at the same position.
REQ-018 in_ready SHALL equal (!out_valid || out_ready) && !load.
REQ-019 Accept occurs when in_valid && in_ready; no other cycle changes data_out.
REQ-020 On accept with step_in=1, position SHALL become (pos+1) mod 26 and the character SHALL be enciphered with the new position (step before encipher).
REQ-021 On accept with step_in=0, position SHALL be unchanged and used as P.
REQ-022 step_in SHALL be ignored in cycles without an accept.
REQ-023 Latency: result registered; out_valid SHALL rise the cycle after accept.
REQ-024 out_valid SHALL stay high with data_out/err stable until out_ready; it clears on out_ready without a same-cycle accept; a same-cycle accept replaces the result (full throughput).
REQ-025 Position arithmetic SHALL use 7-bit intermediate and subtract 26 when >=26; position 25 steps to 0.
REQ-026 carry_out SHALL pulse for exactly the cycle after an accept that steps position from NOTCH to NOTCH+1.
REQ-027 load with load_pos<=25 SHALL set position next cycle; load_pos>25 SHALL be ignored; load never alters out_valid/data_out.
REQ-028 data_in>25 on accept SHALL produce data_out=6'd63, err=1; stepping still applies.
REQ-029 pos_out SHALL reflect the registered position.

Reset
REQ-030 rst_n low SHALL immediately clear position to 0, out_valid 0, data_out 0, err 0, carry_out 0.
REQ-031 Reset mid-handshake SHALL discard the pending result; in_ready=1 first cycle after release.

Structure
REQ-032 enigma_pkg SHALL hold LETTER_W=6, NUM_LETTERS=26, BAD_CODE=6'd63 and the rotor II wiring table.
REQ-033 One sub-module rotor2_wiring_rom (combinational 6-bit index -> 6-bit letter) SHALL implement W.
REQ-034 No initial blocks for functional state; all state reset by rst_n.

Verification
REQ-035 Reset, pos 0, data_in=0, step_in=0, out_ready=1 -> data_out=6 (G), pos_out=0.
REQ-036 pos 0, data_in=0, step_in=1 -> pos_out=1, data_out=11 (L).
REQ-037 load_pos=4, accept data_in=0 step_in=1 -> pos_out=5, data_out=1 (B), carry_out one-cycle pulse; load_pos=25 then step -> pos_out=0, no carry.
REQ-038 out_ready=0 for 3 cycles after result -> out_valid, data_out held, in_ready=0; out_ready=1 -> next character accepted same cycle.
REQ-039 data_in=30 accepted -> data_out=63, err=1; load_pos=40 -> pos_out unchanged.
REQ-040 rst_n low while out_valid=1 -> out_valid, pos_out, carry_out 0 immediately, before next clk.
